// File: rtl/ddr_wr_burst_ctrl.sv
// Drains 128-bit words from the write FIFO and issues fixed-length INCR write
// bursts over a linear, wrapping frame buffer address space.
module ddr_wr_burst_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 28,
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned LEVEL_WIDTH = 11,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_BYTES = 1572864
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   frame_start,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_level,
  output logic [ADDR_WIDTH-1:0]  aw_addr,
  output logic [7:0]             aw_len,
  output logic                   aw_valid,
  input  logic                   aw_ready,
  output logic [DATA_WIDTH-1:0]  w_data,
  output logic                   w_valid,
  output logic                   w_last,
  input  logic                   w_ready,
  input  logic                   b_valid,
  input  logic [1:0]             b_resp,
  output logic                   b_ready,
  output logic                   busy,
  output logic                   resp_err
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] FRAME_END   = ADDR_WIDTH'(BASE_ADDR + FRAME_BYTES);
  localparam logic [CNT_W-1:0]      BURST_CNT   = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      fetched;
  logic [CNT_W-1:0]      beat;
  logic                  rd_pending;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic                  rebase_pend;
  logic                  pop;
  logic [1:0]            occ_after;

  assign aw_len   = 8'(BURST_LEN - 1);
  assign aw_valid = (state == ADDR);
  assign b_ready  = (state == RESP);
  assign busy     = (state != IDLE);
  assign w_valid  = (state == DATA) && (occ != 2'd0);
  assign w_data   = buf0;
  assign w_last   = w_valid && (beat == LAST_BEAT);
  assign pop      = w_valid && w_ready;

  // Occupancy as it will stand after this edge: a beat popped now frees a slot
  // for a read issued now, which keeps one beat per cycle with a 2-entry buffer.
  assign occ_after  = occ - {1'b0, pop} + {1'b0, rd_pending};
  assign fifo_rd_en = ((state == ADDR) || (state == DATA)) && !fifo_rd_empty &&
                      (fetched < BURST_CNT) && (occ_after < 2'd2);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state       <= IDLE;
      aw_addr     <= BASE;
      fetched     <= '0;
      beat        <= '0;
      rd_pending  <= 1'b0;
      occ         <= '0;
      buf0        <= '0;
      buf1        <= '0;
      rebase_pend <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      rd_pending <= fifo_rd_en;
      if (fifo_rd_en) fetched <= fetched + 1'b1;
      if (pop)        beat    <= beat + 1'b1;

      // Head register only moves on a pop or when filling an empty buffer.
      if (pop && rd_pending) begin
        if (occ == 2'd1) begin
          buf0 <= fifo_rd_data;
        end else begin
          buf0 <= buf1;
          buf1 <= fifo_rd_data;
        end
      end else if (pop) begin
        buf0 <= buf1;
        occ  <= occ - 2'd1;
      end else if (rd_pending) begin
        if (occ == 2'd0) buf0 <= fifo_rd_data;
        else             buf1 <= fifo_rd_data;
        occ <= occ + 2'd1;
      end

      if (b_valid && b_ready && (b_resp != 2'd0)) resp_err <= 1'b1;

      case (state)
        IDLE: begin
          fetched <= '0;
          beat    <= '0;
          if (frame_start) aw_addr <= BASE;
          if (fifo_rd_level >= LEVEL_WIDTH'(BURST_LEN)) state <= ADDR;
        end
        ADDR: begin
          if (frame_start) rebase_pend <= 1'b1;
          if (aw_ready)    state <= DATA;
        end
        DATA: begin
          if (frame_start)   rebase_pend <= 1'b1;
          if (pop && w_last) state <= RESP;
        end
        RESP: begin
          if (b_valid) begin
            if (rebase_pend || frame_start)         aw_addr <= BASE;
            else if (aw_addr + BURST_BYTES == FRAME_END) aw_addr <= BASE;
            else                                    aw_addr <= aw_addr + BURST_BYTES;
            rebase_pend <= 1'b0;
            state       <= IDLE;
          end else if (frame_start) begin
            rebase_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Scoreboard bench for ddr_wr_burst_ctrl: FIFO and AXI slave models, expected
// addresses/beats queued by stimulus and consumed by a monitor.
module tb_ddr_wr_burst_ctrl;

  localparam int unsigned FRAME = 32'h1800;

  logic         rd_clk = 1'b0;
  logic         rd_rst = 1'b1;
  logic         frame_start = 1'b0;
  logic         fifo_rd_en;
  logic [127:0] fifo_rd_data = '0;
  logic         fifo_rd_empty = 1'b1;
  logic [10:0]  fifo_rd_level = '0;
  logic [27:0]  aw_addr;
  logic [7:0]   aw_len;
  logic         aw_valid;
  logic         aw_ready = 1'b0;
  logic [127:0] w_data;
  logic         w_valid;
  logic         w_last;
  logic         w_ready = 1'b0;
  logic         b_valid = 1'b0;
  logic [1:0]   b_resp = '0;
  logic         b_ready;
  logic         busy;
  logic         resp_err;

  always #5 rd_clk = ~rd_clk;

  ddr_wr_burst_ctrl #(.BURST_LEN(16), .FRAME_BYTES(FRAME)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .frame_start(frame_start),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_level(fifo_rd_level),
    .aw_addr(aw_addr), .aw_len(aw_len), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_valid(w_valid), .w_last(w_last), .w_ready(w_ready),
    .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
    .busy(busy), .resp_err(resp_err)
  );

  typedef struct {
    logic [127:0] d;
    logic         last;
  } beat_t;

  int           errors = 0;
  int           checks = 0;
  logic [127:0] fq[$];
  beat_t        exp_w[$];
  logic [27:0]  exp_aw[$];
  int           bursts_done = 0;
  int           rd_pulses = 0;
  int           beats = 0;
  int           b_owed = 0;
  int unsigned  push_idx = 0;
  logic [31:0]  seq = 32'h1;
  bit           rd_fire = 0;
  bit           rand_mode = 0;
  bit           err_en = 0;
  logic [27:0]  err_addr = '0;
  logic [27:0]  cur_addr = '0;
  bit           prev_aw_stall = 0;
  bit           prev_w_stall = 0;
  logic [27:0]  prev_aw_addr = '0;
  logic [127:0] prev_w_data = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic upd_level();
    fifo_rd_level = 11'(fq.size());
    fifo_rd_empty = (fq.size() == 0);
  endtask

  task automatic push_words(input int n);
    logic [127:0] word;
    for (int i = 0; i < n; i++) begin
      word = {seq * 32'h9E3779B9, seq, ~seq, seq ^ 32'hC0DE0000};
      fq.push_back(word);
      exp_w.push_back('{word, (push_idx % 16) == 15});
      push_idx++;
      seq++;
    end
    upd_level();
  endtask

  task automatic push_burst(input logic [27:0] addr);
    exp_aw.push_back(addr);
    push_words(16);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge rd_clk);
    #2;
  endtask

  task automatic wait_bursts(input int target);
    int n = 0;
    while (bursts_done < target && n < 3000) begin
      cyc(1);
      n++;
    end
    check("burst_done_timeout", 128'(bursts_done >= target), 128'(1));
  endtask

  // Bus models and monitor: drive slave inputs at negedge, then evaluate the
  // handshakes that the following posedge will perform.
  always @(negedge rd_clk) begin
    if (rd_rst) begin
      rd_fire = 0; b_owed = 0; b_valid = 1'b0; beats = 0;
      prev_aw_stall = 0; prev_w_stall = 0;
    end else begin
      if (rd_fire) begin
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL fifo_underflow: got read with 0 words, expected none");
        end else begin
          fifo_rd_data = fq.pop_front();
        end
        upd_level();
      end
      w_ready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      aw_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      b_valid  = (b_owed > 0);
      b_resp   = (err_en && cur_addr == err_addr) ? 2'd2 : 2'd0;
      #1;
      if (prev_aw_stall) check("aw_hold", {aw_valid, aw_addr}, {1'b1, prev_aw_addr});
      if (prev_w_stall) begin
        check("w_hold_valid", 128'(w_valid), 128'(1));
        check("w_hold_data", w_data, prev_w_data);
      end
      if (aw_valid && aw_ready) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 128'(aw_addr), 128'(0));
        else check("aw_addr", 128'(aw_addr), 128'(exp_aw.pop_front()));
        check("aw_len", 128'(aw_len), 128'(15));
        cur_addr = aw_addr;
      end
      if (w_valid && w_ready) begin
        if (exp_w.size() == 0) begin
          check("w_unexpected", 128'(w_valid), 128'(0));
        end else begin
          beat_t e;
          e = exp_w.pop_front();
          check("w_data", w_data, e.d);
          check("w_last", 128'(w_last), 128'(e.last));
        end
        beats++;
        if (w_last) begin
          b_owed++;
          beats = 0;
        end
      end
      if (b_valid && b_ready) begin
        b_owed--;
        bursts_done++;
      end
      prev_aw_stall = aw_valid && !aw_ready;
      prev_aw_addr  = aw_addr;
      prev_w_stall  = w_valid && !w_ready;
      prev_w_data   = w_data;
      rd_fire = fifo_rd_en;
      if (fifo_rd_en) rd_pulses++;
    end
  end

  initial begin
    int r0;
    int n;
    cyc(3);
    check("rst_aw_valid", 128'(aw_valid), 128'(0));
    check("rst_w_valid", 128'(w_valid), 128'(0));
    check("rst_w_last", 128'(w_last), 128'(0));
    check("rst_w_data", w_data, 128'(0));
    check("rst_fifo_rd_en", 128'(fifo_rd_en), 128'(0));
    check("rst_b_ready", 128'(b_ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_resp_err", 128'(resp_err), 128'(0));
    check("rst_aw_addr", 128'(aw_addr), 128'(0));
    check("rst_aw_len", 128'(aw_len), 128'(15));
    rd_rst = 1'b0;

    // Level 15 must not start a burst; the 16th word does.
    cyc(2);
    push_words(15);
    repeat (8) begin
      cyc(1);
      check("lvl15_aw_valid", 128'(aw_valid), 128'(0));
      check("lvl15_busy", 128'(busy), 128'(0));
    end
    exp_aw.push_back(28'h0);
    push_words(1);
    wait_bursts(1);
    cyc(2);
    check("addr_after_first", 128'(aw_addr), 128'(28'h100));

    // Random backpressure over 4 bursts.
    rand_mode = 1;
    r0 = rd_pulses;
    for (int i = 1; i <= 4; i++) push_burst(28'(i * 32'h100));
    wait_bursts(5);
    rand_mode = 0;
    cyc(2);
    check("rd_pulses_4bursts", 128'(rd_pulses - r0), 128'(64));

    // Double frame_start during DATA of the 0x500 burst: one rebase afterwards.
    push_burst(28'h500);
    n = 0;
    while (!w_valid && n < 100) begin cyc(1); n++; end
    frame_start = 1'b1; cyc(1); frame_start = 1'b0;
    cyc(2);
    frame_start = 1'b1; cyc(1); frame_start = 1'b0;
    wait_bursts(6);
    cyc(2);
    check("rebase_addr", 128'(aw_addr), 128'(0));

    // Error response on the third burst of the frame.
    err_addr = 28'h200;
    err_en = 1;
    push_burst(28'h0);
    push_burst(28'h100);
    wait_bursts(8);
    check("resp_err_before", 128'(resp_err), 128'(0));
    push_burst(28'h200);
    wait_bursts(9);
    check("resp_err_set", 128'(resp_err), 128'(1));
    err_en = 0;
    push_burst(28'h300);
    wait_bursts(10);
    cyc(2);
    check("resp_err_sticky", 128'(resp_err), 128'(1));
    check("addr_after_err", 128'(aw_addr), 128'(28'h400));

    // Run to the end of the frame and wrap.
    for (int a = 32'h400; a < FRAME; a += 32'h100) push_burst(28'(a));
    wait_bursts(30);
    cyc(2);
    check("wrap_addr", 128'(aw_addr), 128'(0));

    // frame_start in IDLE rebases on the next cycle.
    push_burst(28'h0);
    wait_bursts(31);
    cyc(2);
    check("pre_idle_rebase", 128'(aw_addr), 128'(28'h100));
    frame_start = 1'b1; cyc(1); frame_start = 1'b0;
    check("idle_rebase", 128'(aw_addr), 128'(0));

    // Asynchronous reset in the middle of the 0x200 burst.
    push_burst(28'h0);
    push_burst(28'h100);
    push_burst(28'h200);
    wait_bursts(33);
    n = 0;
    while (beats != 7 && n < 200) begin cyc(1); n++; end
    check("reach_beat7", 128'(beats), 128'(7));
    #1 rd_rst = 1'b1;
    #1;
    check("arst_aw_valid", 128'(aw_valid), 128'(0));
    check("arst_w_valid", 128'(w_valid), 128'(0));
    check("arst_w_last", 128'(w_last), 128'(0));
    check("arst_fifo_rd_en", 128'(fifo_rd_en), 128'(0));
    check("arst_b_ready", 128'(b_ready), 128'(0));
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_resp_err", 128'(resp_err), 128'(0));
    check("arst_aw_addr", 128'(aw_addr), 128'(0));
    check("arst_w_data", w_data, 128'(0));
    fq.delete();
    exp_w.delete();
    exp_aw.delete();
    push_idx = 0;
    upd_level();
    cyc(3);
    rd_rst = 1'b0;
    cyc(1);
    push_burst(28'h0);
    wait_bursts(34);
    cyc(2);
    check("post_rst_addr", 128'(aw_addr), 128'(28'h100));
    check("exp_aw_drained", 128'(exp_aw.size()), 128'(0));
    check("exp_w_drained", 128'(exp_w.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_wr_burst_ctrl.md
Name: ddr_wr_burst_ctrl

Overview:
- Sits directly downstream of the 16-to-128-bit write FIFO, on its read side.
- Drains 128-bit words from the FIFO and issues fixed-length AXI4-style INCR write bursts to the DDR controller user port.
- Frame buffer addressing is linear from BASE_ADDR; it wraps after FRAME_BYTES and is re-based on frame_start.

Parameters:
- ADDR_WIDTH, 28, byte address width of aw_addr.
- DATA_WIDTH, 128, FIFO read / AXI data width; fixed at 128.
- LEVEL_WIDTH, 11, width of fifo_rd_level (FIFO read depth width + 1).
- BURST_LEN, 16, beats per burst (1..256); aw_len = BURST_LEN-1.
- BASE_ADDR, 0, frame start byte address; must be aligned to BURST_BYTES = BURST_LEN*DATA_WIDTH/8.
- FRAME_BYTES, 1572864, frame size in bytes; must be a multiple of BURST_BYTES.

Ports:
- rd_clk, input, 1, DDR user clock; also the FIFO read clock.
- rd_rst, input, 1, asynchronous active-high reset.
- frame_start, input, 1, 1-cycle pulse: next burst starts at BASE_ADDR.
- fifo_rd_en, output, 1, FIFO read enable.
- fifo_rd_data, input, 128, FIFO read data; valid the cycle after fifo_rd_en.
- fifo_rd_empty, input, 1, FIFO empty flag.
- fifo_rd_level, input, LEVEL_WIDTH, FIFO read-side water level in 128-bit words.
- aw_addr, output, ADDR_WIDTH, burst byte address.
- aw_len, output, 8, constant BURST_LEN-1.
- aw_valid, output, 1, address valid.
- aw_ready, input, 1, address accept.
- w_data, output, 128, write data.
- w_valid, output, 1, data valid.
- w_last, output, 1, final beat of burst.
- w_ready, input, 1, data accept.
- b_valid, input, 1, write response valid.
- b_resp, input, 2, response code; 0 = OKAY.
- b_ready, output, 1, response accept.
- busy, output, 1, FSM not in IDLE.
- resp_err, output, 1, sticky; set on any b_resp != 0.

Behaviour:
- Reset (async assert, release on the rd_clk edge): FSM=IDLE; aw_addr=BASE_ADDR; all valid/ready/enable outputs 0; w_data=0; w_last=0; busy=0; resp_err=0; beat counters=0; skid buffer empty.
- FSM states:
  - IDLE -> ADDR when fifo_rd_level >= BURST_LEN. Burst data is guaranteed present before the burst starts, so data never starves mid-burst.
  - ADDR: aw_valid=1, aw_addr held stable until aw_ready. Handshake at aw_valid&aw_ready -> DATA.
  - DATA: stream BURST_LEN beats. After the beat with w_last=1 is accepted -> RESP.
  - RESP: b_ready=1. On b_valid, advance the address and return to IDLE. IDLE re-evaluates the level next cycle (one-cycle bubble per burst is intended).
- Prefetch:
  - FIFO reads may start in ADDR, so first data overlaps the address phase.
  - A 2-entry skid buffer sits between the FIFO and w_data/w_valid.
  - fifo_rd_en=1 only when all hold: state in {ADDR, DATA}; !fifo_rd_empty; words_fetched < BURST_LEN; (buffer occupancy + read in flight) < 2.
  - Exactly BURST_LEN reads per burst; never reads past the burst.
  - w_valid = buffer non-empty, and only in DATA.
  - w_data/w_valid hold stable while w_ready=0 (AXI rule; no combinational path from w_ready to w_data).
  - w_last=1 exactly on beat BURST_LEN-1 (beat counter 0-based).
- Address update (in RESP on b_valid):
  - frame_start latched -> aw_addr=BASE_ADDR, latch cleared.
  - else if aw_addr+BURST_BYTES == BASE_ADDR+FRAME_BYTES -> BASE_ADDR (wrap).
  - else aw_addr += BURST_BYTES.
  - Arithmetic is in ADDR_WIDTH bits.
- frame_start:
  - In IDLE: aw_addr=BASE_ADDR on the next cycle.
  - In any other state: latched, applied at burst completion; the current burst is never aborted or re-addressed.
  - Multiple pulses during one burst = one rebase.
- Simultaneous events:
  - aw handshake and first-beat availability in the same cycle: w_valid may assert the next cycle.
  - b_valid and frame_start in the same cycle: rebase wins.
- resp_err: set on b_valid & b_ready & b_resp != 0. Cleared only by rd_rst. The FSM continues normally after an error (no retry).
- Mid-burst rd_rst: all state is dropped immediately and the partial burst is abandoned. The FIFO must be reset in the same event (system-level requirement).
- Throughput: with w_ready=1 continuously, one beat per cycle after the first.

Test Plan:
- Level 15 then 16 -> no aw_valid at 15; at 16, aw_valid with aw_addr=0x0, aw_len=15; 16 w beats with w_last on the 16th; b_valid -> next aw_addr=0x100.
- w_ready toggled randomly 50% over 4 bursts -> w_data matches FIFO order word-for-word; no beat dropped or duplicated; exactly 64 fifo_rd_en pulses.
- Burst writes through the frame, 6144 bursts -> last aw_addr=0x17FF00, next aw_addr=0x0.
- frame_start pulsed during DATA of the burst at 0x500 -> that burst completes at 0x500; next aw_addr=0x0.
- b_resp=2 on burst 3 -> resp_err=1 and stays 1; burst 4 issues normally at 0x300.
- rd_rst asserted mid-DATA at beat 7 -> all outputs at reset values asynchronously; after release, first aw_addr=0x0.
